wb_stage: RTL and testbench

- Writeback stage of the 16-bit pipeline. It sits directly upstream of the register file and produces that block's write port (wen/waddr/wdata) and its R15 link port (r15/r15enable).
- Accepts one retiring instruction per cycle from the memory stage.
- Holds loads until the data memory returns read data, and stalls upstream via in_ready while doing so.
- Filters illegal destinations: R0 is never written; R15 is written only by JAL.

---
 rtl/wb_stage.sv | 131 +++++++++++++
 tb/tb_wb_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: drives the register file write port and the R15 link port,
// holding loads until read data returns. Optional macro: WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int DSIZE        = 16,
  parameter int RSIZE        = 4,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RSIZE-1:0] in_dest,
  input  logic             in_wen,
  input  logic             in_load,
  input  logic             in_jal,
  input  logic [DSIZE-1:0] in_alu,
  input  logic [DSIZE-1:0] in_pc_next,
  input  logic             mem_rvalid,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             wen,
  output logic [RSIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata,
  output logic             r15enable,
  output logic [DSIZE-1:0] r15,
  output logic             load_err,
  output logic [15:0]      retire_count
);

  // state     | meaning
  // IDLE      | ready for a retiring instruction
  // LOAD_WAIT | load accepted, waiting for mem_rvalid or timeout
  typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

  localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t           r_state;
  logic [7:0]       r_tmo;
  logic [RSIZE-1:0] r_ld_dest;
  logic             r_ld_qual;
  logic             r_wen;
  logic [RSIZE-1:0] r_waddr;
  logic [DSIZE-1:0] r_wdata;
  logic             r_r15en;
  logic [DSIZE-1:0] r_r15;
  logic             r_load_err;

  logic w_accept;
  logic w_dest_ok;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_dest_ok = (in_dest != '0) && (in_dest != RSIZE'(15));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tmo      <= '0;
      r_ld_dest  <= '0;
      r_ld_qual  <= 1'b0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_r15en    <= 1'b0;
      r_r15      <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_wen   <= 1'b0;
      r_r15en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (in_load) begin
              r_state   <= LOAD_WAIT;
              r_tmo     <= '0;
              r_ld_dest <= in_dest;
              r_ld_qual <= in_wen && w_dest_ok;
            end else begin
              r_wen   <= in_wen && !in_jal && w_dest_ok;
              r_waddr <= in_dest;
              r_wdata <= in_alu;
              r_r15en <= in_jal;
              r_r15   <= in_pc_next;
            end
          end
        end
        LOAD_WAIT: begin
          // rvalid takes priority over the timeout in the final wait cycle
          if (mem_rvalid) begin
            r_wen   <= r_ld_qual;
            r_waddr <= r_ld_dest;
            r_wdata <= mem_rdata;
            r_state <= IDLE;
          end else if (r_tmo == TMO_LAST) begin
            r_state    <= IDLE;
            r_load_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic        w_retire;
  logic [15:0] r_retire;

  assign w_retire = (w_accept && !in_load) || ((r_state == LOAD_WAIT) && mem_rvalid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire <= '0;
    end else if (w_retire) begin
      r_retire <= r_retire + 16'd1;
    end
  end

  assign retire_count = r_retire;
`else
  assign retire_count = '0;
`endif

  assign in_ready  = (r_state == IDLE);
  assign wen       = r_wen;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign r15enable = r_r15en;
  assign r15       = r_r15;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table, directed load sequences,
// and randomized traffic against a transaction-level reference model.
module tb_wb_stage;

  localparam int LT = 15;

  logic        clk, rst;
  logic        in_valid, in_wen, in_load, in_jal, mem_rvalid;
  logic [3:0]  in_dest;
  logic [15:0] in_alu, in_pc_next, mem_rdata;
  logic        in_ready, wen, r15enable, load_err;
  logic [3:0]  waddr;
  logic [15:0] wdata, r15, retire_count;

  int errors = 0;
  int checks = 0;

  wb_stage #(.DSIZE(16), .RSIZE(4), .LOAD_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_wen(in_wen),
    .in_load(in_load), .in_jal(in_jal), .in_alu(in_alu), .in_pc_next(in_pc_next),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wen(wen), .waddr(waddr), .wdata(wdata), .r15enable(r15enable), .r15(r15),
    .load_err(load_err), .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: pending-load record plus expected registered outputs
  logic        m_busy;
  int          m_left;
  logic [3:0]  m_dest;
  logic        m_qual;
  logic        e_wen, e_r15en, e_err;
  logic [3:0]  e_waddr;
  logic [15:0] e_wdata, e_r15, e_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_left = 0; m_dest = 0; m_qual = 0;
    e_wen = 0; e_r15en = 0; e_err = 0; e_waddr = 0; e_wdata = 0; e_r15 = 0; e_cnt = 0;
  endtask

  task automatic model_step();
    e_wen = 0;
    e_r15en = 0;
    if (!m_busy) begin
      if (in_valid && in_load) begin
        m_busy = 1;
        m_left = LT;
        m_dest = in_dest;
        m_qual = in_wen && in_dest != 0 && in_dest != 15;
      end else if (in_valid) begin
        e_wen   = in_wen && !in_jal && in_dest != 0 && in_dest != 15;
        e_waddr = in_dest;
        e_wdata = in_alu;
        e_r15en = in_jal;
        e_r15   = in_pc_next;
        e_cnt   = e_cnt + 16'd1;
      end
    end else if (mem_rvalid) begin
      e_wen   = m_qual;
      e_waddr = m_dest;
      e_wdata = mem_rdata;
      m_busy  = 0;
      e_cnt   = e_cnt + 16'd1;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        e_err  = 1;
      end
    end
  endtask

  task automatic check_outs();
    chk("wen", wen, e_wen);
    if (e_wen) begin
      chk("waddr", waddr, e_waddr);
      chk("wdata", wdata, e_wdata);
    end
    chk("r15enable", r15enable, e_r15en);
    if (e_r15en) chk("r15", r15, e_r15);
    chk("load_err", load_err, e_err);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_count", retire_count, e_cnt);
`else
    chk("retire_count", retire_count, 16'h0);
`endif
  endtask

  task automatic tick();
    chk("in_ready", in_ready, !m_busy);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic set_idle();
    in_valid = 0; in_wen = 0; in_load = 0; in_jal = 0; in_dest = 0;
    in_alu = 0; in_pc_next = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic issue_load(input logic [3:0] d);
    set_idle();
    in_valid = 1; in_load = 1; in_wen = 1; in_dest = d; in_jal = 1;
    mem_rvalid = 1; mem_rdata = 16'hDEAD;   // rvalid in accept cycle must be ignored
    tick();
    set_idle();
  endtask

  typedef struct {
    logic [3:0]  dest;
    logic        w;
    logic        jal;
    logic [15:0] alu;
    logic [15:0] pc;
    logic        exp_wen;
    logic        exp_r15en;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{4'd3,  1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{4'd0,  1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vt[2] = '{4'd15, 1'b1, 1'b0, 16'h5555, 16'h0000, 1'b0, 1'b0};
    vt[3] = '{4'd7,  1'b1, 1'b1, 16'h0101, 16'h0042, 1'b0, 1'b1};
    vt[4] = '{4'd9,  1'b0, 1'b0, 16'hAAAA, 16'h0000, 1'b0, 1'b0};
    vt[5] = '{4'd14, 1'b1, 1'b0, 16'h7777, 16'h0000, 1'b1, 1'b0};
    vt[6] = '{4'd1,  1'b1, 1'b0, 16'h8001, 16'h0000, 1'b1, 1'b0};

    rst = 1;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    rst = 0;
    check_outs();

    // vector table, back-to-back accepts
    for (int i = 0; i < 7; i++) begin
      set_idle();
      in_valid = 1; in_dest = vt[i].dest; in_wen = vt[i].w; in_jal = vt[i].jal;
      in_alu = vt[i].alu; in_pc_next = vt[i].pc;
      tick();
      chk("vec_wen", wen, vt[i].exp_wen);
      chk("vec_r15en", r15enable, vt[i].exp_r15en);
    end
    set_idle();
    tick();
    chk("pulse_end_wen", wen, 1'b0);

    // load dest=5, rvalid three cycles after accept
    issue_load(4'd5);
    tick();
    tick();
    mem_rvalid = 1; mem_rdata = 16'hBEEF;
    tick();
    set_idle();
    chk("load_wen", wen, 1'b1);
    chk("load_wdata", wdata, 16'hBEEF);
    chk("load_ready", in_ready, 1'b1);

    // minimum latency load, dest=15 filtered
    issue_load(4'd15);
    mem_rvalid = 1; mem_rdata = 16'h1111;
    tick();
    set_idle();
    chk("load15_wen", wen, 1'b0);

    // rvalid in the final wait cycle wins over the timeout
    issue_load(4'd6);
    for (int i = 0; i < LT - 1; i++) tick();
    mem_rvalid = 1; mem_rdata = 16'hC0DE;
    tick();
    set_idle();
    chk("edge_wen", wen, 1'b1);
    chk("edge_err", load_err, 1'b0);

    // timeout
    issue_load(4'd8);
    for (int i = 0; i < LT; i++) tick();
    chk("tmo_err", load_err, 1'b1);
    chk("tmo_ready", in_ready, 1'b1);
    chk("tmo_wen", wen, 1'b0);

    // reset mid-wait clears everything immediately
    issue_load(4'd4);
    tick();
    #2 rst = 1;
    #1;
    model_reset();
    chk("rst_wen", wen, 1'b0);
    chk("rst_err", load_err, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_wdata", wdata, 16'h0);
    chk("rst_cnt", retire_count, 16'h0);
    @(negedge clk);
    rst = 0;

    // retire count: 3 ALU ops, 1 completed load, 1 timed-out load
    for (int i = 0; i < 3; i++) begin
      set_idle();
      in_valid = 1; in_wen = 1; in_dest = 4'(i + 2); in_alu = 16'(i * 3);
      tick();
    end
    issue_load(4'd2);
    mem_rvalid = 1; mem_rdata = 16'h4444;
    tick();
    issue_load(4'd3);
    for (int i = 0; i < LT; i++) tick();
`ifdef WB_RETIRE_CNT_EN
    chk("retire_total", retire_count, 16'd4);
`else
    chk("retire_total", retire_count, 16'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_load    = ($urandom_range(0, 3) == 0);
      in_jal     = ($urandom_range(0, 4) == 0);
      in_wen     = ($urandom_range(0, 3) != 0);
      in_dest    = 4'($urandom_range(0, 15));
      in_alu     = 16'($urandom);
      in_pc_next = 16'($urandom);
      mem_rvalid = ($urandom_range(0, 4) == 0);
      mem_rdata  = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
